icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache directly upstream of the core's fetch port.

---
 rtl/icache_dm.sv | 207 ++++++++++++++++++++
 tb/tb_icache_dm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the fetch stage and a
// word-wide backing memory. Hits answer one cycle after the request; misses
// refill the whole line one word per mem_ack_i, then answer from a captured copy.
module icache_dm #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wen_i,
    input  logic              flush_i,
    output logic              data_valid_o,
    output logic [31:0]       data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
    localparam int LINE_W = TAG_W + IDX_W;   // {tag, index}: line base without offset
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_e;

    // Fetch address split: byte bits are dropped, offset picks the word in a line.
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_byte_bits;

    assign req_off          = addr_i[OFF_W+1:2];
    assign req_idx          = addr_i[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag          = addr_i[ADDR_W-1:IDX_W+OFF_W+2];
    assign unused_byte_bits = ^addr_i[1:0];

    // Storage arrays: valid bits are resettable state, tag/data are plain RAM.
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      words_q[LINES*LINE_WORDS];

    // Control state
    state_e           state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;        // {tag, index} of the line being refilled
    logic [OFF_W-1:0] off_q, off_d;           // word the core asked for
    logic [OFF_W-1:0] beat_q, beat_d;         // refill word counter
    logic [31:0]      cap_q, cap_d;           // requested word captured during refill
    logic             drop_q, drop_d;         // core withdrew the request mid-refill
    logic             flushed_q, flushed_d;   // flush seen mid-refill: do not validate line
    logic             data_valid_q, data_valid_d;
    logic [31:0]      data_q, data_d;

    // Array write controls
    logic             word_we;
    logic             tag_we;

    // Refill line decomposition
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[LINE_W-1:IDX_W];

    // Combinational lookup on the live fetch address
    logic        hit;
    logic [31:0] rd_word;

    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rd_word = words_q[{req_idx, req_off}];

    // Next-state, response and array-write decode for the IDLE/REFILL/RESP FSM
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        line_d       = line_q;
        off_d        = off_q;
        beat_d       = beat_q;
        cap_d        = cap_q;
        drop_d       = drop_q;
        flushed_d    = flushed_q;
        valid_d      = valid_q;
        data_valid_d = 1'b0;
        data_d       = '0;
        word_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (wen_i) begin
                        // Invalidate only if this address actually owns the line.
                        if (hit) begin
                            valid_d[req_idx] = 1'b0;
                        end
                        data_valid_d = 1'b1;
                    end else if (hit) begin
                        data_valid_d = 1'b1;
                        data_d       = rd_word;
                    end else begin
                        line_d    = {req_tag, req_idx};
                        off_d     = req_off;
                        beat_d    = '0;
                        drop_d    = 1'b0;
                        flushed_d = 1'b0;
                        // The line is overwritten word by word, so it must not
                        // look valid under its old tag while the refill runs.
                        valid_d[req_idx] = 1'b0;
                        state_d   = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                if (!req_valid_i) begin
                    drop_d = 1'b1;
                end
                if (flush_i) begin
                    flushed_d = 1'b1;
                end
                if (mem_ack_i) begin
                    word_we = 1'b1;
                    if (beat_q == off_q) begin
                        cap_d = mem_data_i;
                    end
                    beat_d = beat_q + OFF_W'(1);   // wraps to 0 after the last beat
                    if (beat_q == LAST_BEAT) begin
                        tag_we            = 1'b1;
                        valid_d[fill_idx] = !(flush_i || flushed_q);
                        state_d           = S_RESP;
                    end
                end
            end

            S_RESP: begin
                data_valid_d = !drop_q;
                data_d       = drop_q ? 32'h0 : cap_q;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything else in any state.
        if (flush_i) begin
            valid_d = '0;
        end
    end

    // Control registers and valid bits with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            off_q        <= '0;
            beat_q       <= '0;
            cap_q        <= '0;
            drop_q       <= 1'b0;
            flushed_q    <= 1'b0;
            valid_q      <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            off_q        <= off_d;
            beat_q       <= beat_d;
            cap_q        <= cap_d;
            drop_q       <= drop_d;
            flushed_q    <= flushed_d;
            valid_q      <= valid_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
        end
    end

    // Tag and data array writes during refill
    always_ff @(posedge clk) begin
        // NOTE: tag and data arrays are deliberately not reset; the valid bits
        // gate every read, so their contents are don't-care until a line is installed.
        if (word_we) begin
            words_q[{fill_idx, beat_q}] <= mem_data_i;
        end
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    assign data_valid_o = data_valid_q;
    assign data_o       = data_q;
    assign mem_req_o    = (state_q == S_REFILL);
    assign mem_addr_o   = mem_req_o ? {line_q, beat_q, 2'b00} : '0;

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: stimulus pushes expected responses, a monitor
// pops and compares on every data_valid_o pulse, and a memory model checks the
// refill address sequence while answering with a configurable ack delay.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic [31:0] addr_i;
    logic        wen_i;
    logic        flush_i;
    logic        data_valid_o;
    logic [31:0] data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] maddr_q[$];

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int n_pulses  = 0;
    int ack_delay = 0;

    icache_dm dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .addr_i       (addr_i),
        .wen_i        (wen_i),
        .flush_i      (flush_i),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Backing memory contents: word k lives at byte address 4k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int b = 0; b < 4; b++) begin
            maddr_q.push_back({a[31:4], 4'h0} + 32'(4 * b));
        end
    endtask

    // Issue one request and hold it until data_valid_o, then release it.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_data, input int lat,
                         input bit miss, input bit inval, input string name);
        exp_t e;
        bit   seen;
        @(negedge clk);
        if (miss) push_line(a);
        addr_i      = a;
        wen_i       = inval;
        req_valid_i = 1'b1;
        e.data = exp_data;
        e.due  = cyc + lat;
        e.name = name;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (data_valid_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        req_valid_i = 1'b0;
        wen_i       = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: no data_valid_o within 64 cycles", name);
        end
    endtask

    // Start a miss, withdraw the request mid-refill, and expect no pulse.
    task automatic fetch_drop(input logic [31:0] a, input int hold, input string name);
        int p0;
        bit done;
        @(negedge clk);
        push_line(a);
        addr_i      = a;
        wen_i       = 1'b0;
        req_valid_i = 1'b1;
        p0 = n_pulses;
        repeat (hold) @(negedge clk);
        req_valid_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: refill did not finish within 64 cycles", name);
        end
        repeat (4) @(negedge clk);
        check({name, " no pulse"}, n_pulses, p0);
    endtask

    task automatic flush_pulse(input int delay);
        repeat (delay) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    // Response monitor: compares every pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid_o === 1'b1) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: data_valid_o with data %h, none expected", data_o);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, " data"}, data_o, e.data);
                    check({e.name, " cycle"}, cyc, e.due);
                end
            end
        end
    end

    // Memory model: checks each refill address, acks after ack_delay wait cycles.
    initial begin
        int wcnt;
        wcnt       = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o === 1'b1) begin
                if (maddr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_req: unexpected refill request at %h", mem_addr_o);
                end else begin
                    check("mem_addr", mem_addr_o, maddr_q[0]);
                end
                if (wcnt >= ack_delay) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(mem_addr_o);
                    wcnt       = 0;
                    if (maddr_q.size() > 0) void'(maddr_q.pop_front());
                end else begin
                    mem_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack_i  = 1'b0;
                mem_data_i = '0;
                wcnt       = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        bit found;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        addr_i      = '0;
        wen_i       = 1'b0;
        flush_i     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset data_valid_o", {31'b0, data_valid_o}, 32'h0);
        check("reset data_o", data_o, 32'h0);
        check("reset mem_req_o", {31'b0, mem_req_o}, 32'h0);
        check("reset mem_addr_o", mem_addr_o, 32'h0);

        // Cold miss, zero-wait refill of 0x80000000..0C
        fetch(32'h8000_0008, 32'h7A5A_0002, 6, 1'b1, 1'b0, "cold_miss");

        // Hits: single, then four back-to-back
        fetch(32'h8000_0004, 32'h7A5A_0001, 1, 1'b0, 1'b0, "hit_04");
        fetch(32'h8000_0000, 32'h7A5A_0000, 1, 1'b0, 1'b0, "seq_00");
        fetch(32'h8000_0004, 32'h7A5A_0001, 1, 1'b0, 1'b0, "seq_04");
        fetch(32'h8000_0008, 32'h7A5A_0002, 1, 1'b0, 1'b0, "seq_08");
        fetch(32'h8000_000C, 32'h7A5A_0003, 1, 1'b0, 1'b0, "seq_0C");

        // Conflict on index 0
        fetch(32'h8000_0400, 32'h7A5A_0100, 6, 1'b1, 1'b0, "conflict_400");
        fetch(32'h8000_0000, 32'h7A5A_0000, 6, 1'b1, 1'b0, "conflict_back");
        fetch(32'h8000_0000, 32'h7A5A_0000, 1, 1'b0, 1'b0, "conflict_rehit");

        // Slow memory: three wait cycles before every ack
        ack_delay = 3;
        fetch(32'h8000_001C, 32'h7A5A_0007, 18, 1'b1, 1'b0, "slow_refill");
        ack_delay = 0;
        fetch(32'h8000_0010, 32'h7A5A_0004, 1, 1'b0, 1'b0, "slow_line_hit");

        // Flush after fill
        flush_pulse(1);
        fetch(32'h8000_0000, 32'h7A5A_0000, 6, 1'b1, 1'b0, "after_flush");

        // Flush in the same cycle as a hit: hit served, line gone afterwards
        fork
            fetch(32'h8000_0008, 32'h7A5A_0002, 1, 1'b0, 1'b0, "hit_with_flush");
            flush_pulse(1);
        join
        fetch(32'h8000_0008, 32'h7A5A_0002, 6, 1'b1, 1'b0, "after_hit_flush");

        // Flush mid-refill: data still returned, line not validated
        fork
            fetch(32'h8000_0034, 32'h7A5A_000D, 6, 1'b1, 1'b0, "flush_mid_refill");
            flush_pulse(3);
        join
        fetch(32'h8000_0030, 32'h7A5A_000C, 6, 1'b1, 1'b0, "after_mid_flush");

        // Request withdrawn mid-refill: no pulse, line still installed
        fetch_drop(32'h8000_0020, 2, "drop");
        fetch(32'h8000_0024, 32'h7A5A_0009, 1, 1'b0, 1'b0, "drop_line_hit");

        // Invalidate a filled line
        fetch(32'h8000_0024, 32'h0000_0000, 1, 1'b0, 1'b1, "invalidate");
        fetch(32'h8000_0028, 32'h7A5A_000A, 6, 1'b1, 1'b0, "after_invalidate");

        // Reset during beat 2 of a refill
        @(negedge clk);
        push_line(32'h8000_0040);
        addr_i      = 32'h8000_0048;
        req_valid_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1 && mem_addr_o === 32'h8000_0048) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL reset_mid_refill: beat 2 address never seen");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid mem_req_o", {31'b0, mem_req_o}, 32'h0);
        check("reset_mid data_valid_o", {31'b0, data_valid_o}, 32'h0);
        @(negedge clk);
        rst         = 1'b0;
        req_valid_i = 1'b0;
        maddr_q.delete();
        fetch(32'h8000_0048, 32'h7A5A_0012, 6, 1'b1, 1'b0, "after_reset_refill");

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        check("refill queue drained", maddr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
